// File: rtl/scan_ram_pkg.sv
// rtl/scan_ram_pkg.sv - shared widths and word/address types for the scanning RAM core.
package scan_ram_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - parameterized-width two-flop synchronizer with async active-high reset.
module sync_chain #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q;

endmodule

// File: rtl/scanning_ram_core.sv
// rtl/scanning_ram_core.sv - 32x4 dual-port RAM, synchronized write side, counter-scanned read side.
// Optional SCAN_RAM_WR_FORWARD_EN: same-edge write to the scanned address is forwarded to q.
module scanning_ram_core
  import scan_ram_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int RD_ADDR_LSB = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wren_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] q
);

  addr_t            wr_addr_s;
  data_t            wr_data_s;
  logic             wren_s;
  addr_t            rd_addr_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_t            q_q, q_d;
  data_t            mem [DEPTH];
  logic             unused_cnt;

  sync_chain #(.W(ADDR_W)) u_sync_addr (
    .clk   (clk),
    .reset (reset),
    .d_in  (wr_addr_in),
    .d_out (wr_addr_s)
  );

  sync_chain #(.W(DATA_W)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d_in  (data_in),
    .d_out (wr_data_s)
  );

  sync_chain #(.W(1)) u_sync_wren (
    .clk   (clk),
    .reset (reset),
    .d_in  (wren_in),
    .d_out (wren_s)
  );

  // Only a slice of the counter addresses the RAM; the rest just sets the scan rate.
  assign rd_addr_w  = cnt_q[RD_ADDR_LSB+ADDR_W-1:RD_ADDR_LSB];
  assign unused_cnt = ^cnt_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    q_d = mem[rd_addr_w];
`ifdef SCAN_RAM_WR_FORWARD_EN
    if (wren_s && (wr_addr_s == rd_addr_w)) begin
      q_d = wr_data_s;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      q_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wren_s) begin
      mem[wr_addr_s] <= wr_data_s;
    end
  end

  assign wr_addr = wr_addr_s;
  assign wr_data = wr_data_s;
  assign rd_addr = rd_addr_w;
  assign q       = q_q;

endmodule

// File: tb/tb_scanning_ram_core.sv
// tb/tb_scanning_ram_core.sv - directed self-checking bench for scanning_ram_core (CNT_W=8, RD_ADDR_LSB=3).
module tb_scanning_ram_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] wr_addr_in = '0;
  logic [3:0] data_in = '0;
  logic       wren_in = 1'b0;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] rd_addr;
  logic [3:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  scanning_ram_core #(
    .CNT_W       (8),
    .RD_ADDR_LSB (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_addr_in (wr_addr_in),
    .data_in    (data_in),
    .wren_in    (wren_in),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .q          (q)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at a negedge with cnt=0; the next posedge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wren_in = 1'b0;
    wr_addr_in = '0;
    data_in = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_addr_in = 5'd7;
    data_in = 4'h6;
    wren_in = 1'b1;
    step(2);
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL rst_q got %h exp 0", q); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_bad++; $display("FAIL rst_wr_addr got %h exp 0", wr_addr); end
    n_cmp++; if (wr_data !== 4'h0) begin n_bad++; $display("FAIL rst_wr_data got %h exp 0", wr_data); end
    n_cmp++; if (rd_addr !== 5'd0) begin n_bad++; $display("FAIL rst_rd_addr got %h exp 0", rd_addr); end
    wren_in = 1'b0;
    wr_addr_in = '0;
    data_in = '0;
    reset = 1'b0;
    #1;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL rst_release_q got %h exp 0", q); end
  endtask

  task automatic test_reset_write();
    do_reset();
    wr_addr_in = 5'd0;
    data_in = 4'hF;
    wren_in = 1'b1;
    step(1);
    wren_in = 1'b0;
    step(1);
    n_cmp++; if (wr_addr !== 5'd0) begin n_bad++; $display("FAIL rw_wr_addr got %h exp 0", wr_addr); end
    n_cmp++; if (wr_data !== 4'hF) begin n_bad++; $display("FAIL rw_wr_data got %h exp f", wr_data); end
    step(2);
    n_cmp++; if (q !== 4'hF) begin n_bad++; $display("FAIL rw_q_n3 got %h exp f", q); end
  endtask

  task automatic test_sync_latency();
    do_reset();
    step(1);
    data_in = 4'hA;
    wr_addr_in = 5'd19;
    step(1);
    n_cmp++; if (wr_data !== 4'h0) begin n_bad++; $display("FAIL sync_data_n got %h exp 0", wr_data); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_bad++; $display("FAIL sync_addr_n got %h exp 0", wr_addr); end
    step(1);
    n_cmp++; if (wr_data !== 4'hA) begin n_bad++; $display("FAIL sync_data_n1 got %h exp a", wr_data); end
    n_cmp++; if (wr_addr !== 5'd19) begin n_bad++; $display("FAIL sync_addr_n1 got %h exp 13", wr_addr); end
  endtask

  task automatic test_wren_reset_drop();
    do_reset();
    wr_addr_in = 5'd0;
    data_in = 4'h5;
    wren_in = 1'b1;
    step(1);
    wren_in = 1'b0;
    step(3);
    n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL drop_pre_q got %h exp 5", q); end
    data_in = 4'h3;
    wren_in = 1'b1;
    step(1);
    wren_in = 1'b0;
    reset = 1'b1;
    step(1);
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL drop_rst_q got %h exp 0", q); end
    reset = 1'b0;
    step(1);
    n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL drop_q_e1 got %h exp 5", q); end
    step(3);
    n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL drop_q_e4 got %h exp 5", q); end
  endtask

  task automatic test_read_during_write();
    logic [3:0] exp_m;
    do_reset();
    wr_addr_in = 5'd0;
    data_in = 4'h1;
    wren_in = 1'b1;
    step(1);
    wren_in = 1'b0;
    step(3);
    n_cmp++; if (q !== 4'h1) begin n_bad++; $display("FAIL rdw_preload got %h exp 1", q); end
    data_in = 4'h7;
    wren_in = 1'b1;
    step(1);
    wren_in = 1'b0;
    step(2);
`ifdef SCAN_RAM_WR_FORWARD_EN
    exp_m = 4'h7;
`else
    exp_m = 4'h1;
`endif
    n_cmp++; if (q !== exp_m) begin n_bad++; $display("FAIL rdw_q_m got %h exp %h", q, exp_m); end
    step(1);
    n_cmp++; if (q !== 4'h7) begin n_bad++; $display("FAIL rdw_q_m1 got %h exp 7", q); end
  endtask

  task automatic test_diff_addr();
    do_reset();
    wr_addr_in = 5'd0;
    data_in = 4'h9;
    wren_in = 1'b1;
    step(1);
    wr_addr_in = 5'd5;
    data_in = 4'hC;
    step(1);
    wren_in = 1'b0;
    step(2);
    for (int e = 4; e <= 8; e++) begin
      n_cmp++; if (q !== 4'h9) begin n_bad++; $display("FAIL diff_q_e%0d got %h exp 9", e, q); end
      if (e < 8) step(1);
    end
    step(33);
    n_cmp++; if (rd_addr !== 5'd5) begin n_bad++; $display("FAIL diff_rd_addr got %h exp 5", rd_addr); end
    n_cmp++; if (q !== 4'hC) begin n_bad++; $display("FAIL diff_q_addr5 got %h exp c", q); end
  endtask

  task automatic test_scan_wrap();
    logic [4:0] exp_ra;
    logic [3:0] exp_q;
    int last;
    @(negedge clk);
    wren_in = 1'b1;
    for (int a = 0; a < 32; a++) begin
      wr_addr_in = 5'(a);
      data_in = 4'(a % 16);
      step(1);
    end
    wren_in = 1'b0;
    step(2);
    do_reset();
    for (int e = 1; e <= 264; e++) begin
      step(1);
      last = e - 1;
      exp_ra = 5'((e / 8) % 32);
      exp_q = 4'(((last / 8) % 32) % 16);
      n_cmp++; if (rd_addr !== exp_ra) begin n_bad++; $display("FAIL scan_rd_addr e%0d got %h exp %h", e, rd_addr, exp_ra); end
      n_cmp++; if (q !== exp_q) begin n_bad++; $display("FAIL scan_q e%0d got %h exp %h", e, q, exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_write();
    test_sync_latency();
    test_wren_reset_drop();
    test_read_during_write();
    test_diff_addr();
    test_scan_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
